// File: rtl/frame_lock_pkg.sv
// Shared types and default constants for the frame lock controller.
package frame_lock_pkg;

    localparam int PERIOD_W = 16;
    localparam int CMP_W    = PERIOD_W + 1;

    localparam int NOM_LEN  = 26250;
    localparam int TOL_WIN  = 64;
    localparam int TRIG_OFS = 20853;
    localparam int TMO_LEN  = 52500;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // One bit wider than the period so nom +/- win never wraps.
    function automatic logic period_good(input logic [PERIOD_W-1:0] len,
                                         input int nom, input int win);
        logic [CMP_W-1:0] lo;
        logic [CMP_W-1:0] hi;
        logic [CMP_W-1:0] val;
        lo  = CMP_W'(nom - win);
        hi  = CMP_W'(nom + win);
        val = {1'b0, len};
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/frame_lock_ctrl_if.sv
// Camera VSYNC / measurement-counter / read-sequencer signals of the frame lock controller.
interface frame_lock_ctrl_if;

    logic                                vs_in;
    logic [frame_lock_pkg::PERIOD_W-1:0] tol_in;
    logic                                cnt_clr;
    logic [frame_lock_pkg::PERIOD_W-1:0] frame_len;
    logic                                locked;
    logic                                r_tr;
    logic [7:0]                          err_cnt;

    modport master (
        output vs_in, tol_in,
        input  cnt_clr, frame_len, locked, r_tr, err_cnt
    );

    modport slave (
        input  vs_in, tol_in,
        output cnt_clr, frame_len, locked, r_tr, err_cnt
    );

endinterface

// File: rtl/vs_edge_sync.sv
// Two-flop synchroniser for the asynchronous VSYNC plus a registered rising-edge pulse.
module vs_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_in,
    output logic vs_rise
);

    // [0] first stage, [1] synchronised level, [2] its previous value
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 3'b000;
            vs_rise <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], vs_in};
            vs_rise <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/frame_lock_ctrl.sv
// Frame lock controller: VSYNC period capture, lock FSM and read-trigger generation.
// Optional saturating error statistics enabled by defining FRAME_LOCK_ERR_STAT_EN.
//
//   state     | meaning
//   ST_IDLE   | no VSYNC seen (or lost); wait for a rising edge
//   ST_SYNC   | first capture pending; its period is meaningless and is discarded
//   ST_CHECK  | counting consecutive good periods towards lock
//   ST_LOCKED | locked; read trigger enabled, counting consecutive bad periods
module frame_lock_ctrl #(
    parameter int NOM_LEN  = frame_lock_pkg::NOM_LEN,
    parameter int TOL_WIN  = frame_lock_pkg::TOL_WIN,
    parameter int LOCK_N   = 4,
    parameter int LOSS_N   = 2,
    parameter int TRIG_OFS = frame_lock_pkg::TRIG_OFS,
    parameter int TMO_LEN  = frame_lock_pkg::TMO_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    frame_lock_ctrl_if.slave   bus
);
    import frame_lock_pkg::*;

    localparam logic [PERIOD_W-1:0] TRIG_V  = PERIOD_W'(TRIG_OFS);
    localparam logic [PERIOD_W-1:0] TMO_V   = PERIOD_W'(TMO_LEN);
    localparam logic [PERIOD_W-1:0] TMO_PRE = PERIOD_W'(TMO_LEN - 1);
    localparam logic [7:0]          LOCK_V  = 8'(LOCK_N);
    localparam logic [7:0]          LOSS_V  = 8'(LOSS_N);

    logic                vs_rise;
    logic                cnt_clr_q;
    logic                clr_d1;
    logic                cap;
    logic [PERIOD_W-1:0] frame_len_q;
    logic [PERIOD_W-1:0] phase;
    logic                tmo;
    logic                good;

    state_t              state;
    logic [7:0]          good_cnt;
    logic [7:0]          bad_cnt;
    logic                locked_q;
    logic                r_tr_q;

    vs_edge_sync u_vs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .vs_in   (bus.vs_in),
        .vs_rise (vs_rise)
    );

    // A new edge cancels any capture still in flight so periods never mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_clr_q   <= 1'b0;
            clr_d1      <= 1'b0;
            cap         <= 1'b0;
            frame_len_q <= '0;
            phase       <= '0;
        end else begin
            cnt_clr_q <= vs_rise;
            clr_d1    <= cnt_clr_q & ~vs_rise;
            cap       <= clr_d1 & ~vs_rise;
            if (clr_d1 && !vs_rise)
                frame_len_q <= bus.tol_in;
            if (vs_rise)
                phase <= '0;
            else if (phase != TMO_V)
                phase <= phase + 1'b1;
        end
    end

    // Fires only on the step into TMO_LEN, so a saturated counter does not repeat it.
    assign tmo  = !vs_rise && (phase == TMO_PRE);
    assign good = period_good(frame_len_q, NOM_LEN, TOL_WIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked_q <= 1'b0;
            r_tr_q   <= 1'b0;
        end else begin
            r_tr_q <= (state == ST_LOCKED) && (phase == TRIG_V);
            if (tmo && state != ST_IDLE) begin
                state    <= ST_IDLE;
                good_cnt <= '0;
                bad_cnt  <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (vs_rise)
                            state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (cap) begin
                            state    <= ST_CHECK;
                            good_cnt <= '0;
                        end
                    end
                    ST_CHECK: begin
                        if (cap) begin
                            if (good) begin
                                good_cnt <= good_cnt + 8'd1;
                                if (good_cnt + 8'd1 == LOCK_V) begin
                                    state    <= ST_LOCKED;
                                    bad_cnt  <= '0;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (cap) begin
                            if (good) begin
                                bad_cnt <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + 8'd1;
                                if (bad_cnt + 8'd1 == LOSS_V) begin
                                    state    <= ST_CHECK;
                                    good_cnt <= '0;
                                    locked_q <= 1'b0;
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FRAME_LOCK_ERR_STAT_EN
    logic [7:0] err_q;
    logic       err_evt;

    assign err_evt = ((state == ST_CHECK) || (state == ST_LOCKED)) && ((cap && !good) || tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else if (err_evt && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.frame_len = frame_len_q;
    assign bus.locked    = locked_q;
    assign bus.r_tr      = r_tr_q;

endmodule

// File: tb/tb_frame_lock_ctrl.sv
// Directed/randomised bench for frame_lock_ctrl against a per-frame behavioural model.
// Trigger and timeout offsets are shortened so whole lock sequences fit in a short run.
module tb_frame_lock_ctrl;
    import frame_lock_pkg::*;

    localparam int T_TRIG = 60;
    localparam int T_TMO  = 300;
    localparam int T_LOCK = 4;
    localparam int T_LOSS = 2;
`ifdef FRAME_LOCK_ERR_STAT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;

    bit   m_active, m_discard, m_locked;
    int   m_good, m_bad, m_err, m_len;

    int   bnd [11] = '{26186, 26314, 26185, 26186, 26314, 26250, 26315,
                       26186, 26314, 26250, 26186};

    always #5 clk = ~clk;

    frame_lock_ctrl_if bus();

    frame_lock_ctrl #(
        .NOM_LEN  (NOM_LEN),
        .TOL_WIN  (TOL_WIN),
        .LOCK_N   (T_LOCK),
        .LOSS_N   (T_LOSS),
        .TRIG_OFS (T_TRIG),
        .TMO_LEN  (T_TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_good(input int v);
        return (v >= NOM_LEN - TOL_WIN) && (v <= NOM_LEN + TOL_WIN);
    endfunction

    function automatic int exp_err();
        return ERR_ON ? m_err : 0;
    endfunction

    function automatic int rand_good();
        return NOM_LEN - TOL_WIN + int'($urandom_range(2 * TOL_WIN, 0));
    endfunction

    function automatic int rand_bad();
        if ($urandom_range(1, 0) == 1)
            return NOM_LEN + TOL_WIN + 1 + int'($urandom_range(2000, 0));
        return NOM_LEN - TOL_WIN - 1 - int'($urandom_range(2000, 0));
    endfunction

    function automatic int rand_per();
        return int'($urandom_range(200, 80));
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_reset();
        m_active = 0; m_discard = 0; m_locked = 0;
        m_good = 0; m_bad = 0; m_err = 0; m_len = 0;
    endtask

    task automatic model_edge();
        if (!m_active) begin
            m_active  = 1;
            m_discard = 1;
        end
    endtask

    task automatic model_cap(input int v);
        m_len = v;
        if (m_discard) begin
            m_discard = 0;
            m_good    = 0;
        end else if (m_locked) begin
            if (is_good(v)) m_bad = 0;
            else begin
                bump_err();
                m_bad++;
                if (m_bad == T_LOSS) begin m_locked = 0; m_good = 0; end
            end
        end else if (is_good(v)) begin
            m_good++;
            if (m_good == T_LOCK) begin m_locked = 1; m_bad = 0; end
        end else begin
            bump_err();
            m_good = 0;
        end
    endtask

    task automatic model_tmo();
        if (m_active) begin
            if (!m_discard) bump_err();
            m_active = 0; m_discard = 0; m_locked = 0;
            m_good = 0; m_bad = 0;
        end
    endtask

    // Called #1 after a rising edge; that edge is offset 0 of the new frame.
    task automatic frame(input int tol, input int per);
        bus.tol_in = 16'(tol);
        bus.vs_in  = 1'b1;
        for (int k = 1; k <= per; k++) begin
            @(posedge clk); #1;
            if (k == 4) model_edge();
            if (k == 7) model_cap(tol);
            if (k == T_TMO + 4) model_tmo();
            chk("cnt_clr", 32'(bus.cnt_clr), 32'(k == 4));
            chk("r_tr", 32'(bus.r_tr), 32'((k == T_TRIG + 5) && m_locked));
            chk("locked", 32'(bus.locked), 32'(m_locked));
            if (k == 6) chk("frame_len_cap", 32'(bus.frame_len), 32'(tol));
            if (k == 7 || k == per) chk("frame_len", 32'(bus.frame_len), 32'(m_len));
            if (k == 8 || k == per) chk("err_cnt", 32'(bus.err_cnt), 32'(exp_err()));
            if (k == 8) bus.vs_in = 1'b0;
        end
    endtask

    task automatic chk_outputs_zero();
        chk("rst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
        chk("rst_frame_len", 32'(bus.frame_len), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_r_tr", 32'(bus.r_tr), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    endtask

    // Discarded first period plus four good ones: lock appears on the fifth capture.
    task automatic acquire();
        for (int i = 1; i <= 6; i++) begin
            frame(rand_good(), rand_per());
            if (i == 4) chk("acq_not_yet", 32'(bus.locked), 32'd0);
            if (i == 5) chk("acq_locked", 32'(bus.locked), 32'd1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.vs_in  = 1'b0;
        bus.tol_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // nominal periods from reset
        for (int i = 1; i <= 6; i++) begin
            frame(NOM_LEN, rand_per());
            if (i == 4) chk("nom_not_yet", 32'(bus.locked), 32'd0);
            if (i == 5) chk("nom_locked", 32'(bus.locked), 32'd1);
        end

        // single bad period is tolerated, two in a row drop lock
        frame(26400, rand_per());
        frame(rand_good(), rand_per());
        chk("one_bad_kept", 32'(bus.locked), 32'd1);
        frame(26400, rand_per());
        frame(26400, rand_per());
        chk("two_bad_lost", 32'(bus.locked), 32'd0);
        frame(rand_good(), rand_per());

        // window edges while checking, then while locked
        for (int i = 0; i < 11; i++) frame(bnd[i], rand_per());
        chk("bnd_locked", 32'(bus.locked), 32'd1);
        frame(26315, rand_per());
        frame(26185, rand_per());
        chk("bnd_lost", 32'(bus.locked), 32'd0);
        for (int i = 0; i < 4; i++) frame(rand_good(), rand_per());
        chk("relock", 32'(bus.locked), 32'd1);

        // VSYNC stops: timeout back to idle, then full reacquisition
        frame(26250, T_TMO + 20);
        chk("tmo_unlocked", 32'(bus.locked), 32'd0);
        chk("tmo_len_held", 32'(bus.frame_len), 32'd26250);
        acquire();

        // asynchronous reset in the middle of a locked frame
        frame(rand_good(), 30);
        chk("pre_reset_locked", 32'(bus.locked), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero();
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        acquire();

        // second edge two cycles after the first: first capture must be dropped
        bus.tol_in = 16'd26000;
        bus.vs_in  = 1'b1;
        @(posedge clk); #1 bus.vs_in = 1'b0;
        @(posedge clk); #1 bus.vs_in = 1'b1;
        for (int k = 3; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 4) model_edge();
            if (k == 9) model_cap(26100);
            chk("drop_cnt_clr", 32'(bus.cnt_clr), 32'(k == 4 || k == 6));
            chk("drop_locked", 32'(bus.locked), 32'(m_locked));
            chk("drop_r_tr", 32'(bus.r_tr), 32'd0);
            if (k == 6) begin
                chk("drop_len_held", 32'(bus.frame_len), 32'(m_len));
                bus.tol_in = 16'd26100;
            end
            if (k == 8) begin
                chk("drop_len_new", 32'(bus.frame_len), 32'd26100);
                bus.vs_in = 1'b0;
            end
        end
        frame(rand_good(), rand_per());

        // long run of bad periods for error statistics
        for (int i = 0; i < 300; i++) frame(rand_bad(), int'($urandom_range(40, 20)));
        chk("err_final", 32'(bus.err_cnt), ERR_ON ? 32'd255 : 32'd0);
        chk("err_final_unlocked", 32'(bus.locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
